// File: rtl/bounce_box_gen_if.sv
// Pixel-position / colour bus between the sync stage and the bounce box sprite generator.
`timescale 1ns/1ps
interface bounce_box_gen_if #(
  parameter int CD = 12
);
  logic [10:0]   x;
  logic [10:0]   y;
  logic [1:0]    speed;
  logic [CD-1:0] box_rgb;
  logic          frame_tick;

  modport master (output x, y, speed, input box_rgb, frame_tick);
  modport slave  (input x, y, speed, output box_rgb, frame_tick);
endinterface

// File: rtl/bounce_box_gen.sv
// Bouncing square sprite: moves once per frame, reflects off screen edges, draws a registered pixel.
// Optional sprite colour cycling on each bounce is enabled by defining BOUNCE_BOX_COLOR_CYCLE_EN.
`timescale 1ns/1ps
module bounce_box_gen #(
  parameter int            CD       = 12,
  parameter int            H_ACTIVE = 640,
  parameter int            V_ACTIVE = 480,
  parameter int            BOX_SIZE = 32,
  parameter logic [CD-1:0] FG_RGB   = 12'hF00,
  parameter logic [CD-1:0] BG_RGB   = 12'h00F
) (
  input  logic       clk,
  input  logic       reset,
  bounce_box_gen_if.slave bus
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] BOX   = 12'(BOX_SIZE);

  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
    logic        hit;
  } axis_t;

  logic [10:0] box_x, box_y;
  logic        dir_x, dir_y;
  logic        tick;
  logic [10:0] step;
  axis_t       nx, ny;
  logic        in_active, in_box;
  logic [CD-1:0] sprite_rgb, pix_rgb;

  // One axis of motion: clamp to the wall and reverse on contact; a zero step freezes everything.
  function automatic axis_t axis_next(input logic [10:0] pos, input logic dir,
                                      input logic [10:0] stp, input logic [10:0] lim);
    axis_t r;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (stp != '0) begin
      if (dir) begin
        if (({1'b0, pos} + {1'b0, stp}) >= {1'b0, lim}) begin
          r.pos = lim;
          r.dir = 1'b0;
          r.hit = 1'b1;
        end else begin
          r.pos = pos + stp;
        end
      end else if (pos <= stp) begin
        r.pos = '0;
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - stp;
      end
    end
    return r;
  endfunction

  always_comb begin
    tick = (bus.x == '0) && (bus.y == 11'(V_ACTIVE));
    step = {9'b0, bus.speed};
    nx   = axis_next(box_x, dir_x, step, X_MAX);
    ny   = axis_next(box_y, dir_y, step, Y_MAX);
  end

`ifdef BOUNCE_BOX_COLOR_CYCLE_EN
  logic [1:0] color_idx;

  always_comb begin
    sprite_rgb = FG_RGB;
    case (color_idx)
      2'd0: sprite_rgb = FG_RGB;
      2'd1: sprite_rgb = CD'(12'h0F0);
      2'd2: sprite_rgb = CD'(12'hFF0);
      2'd3: sprite_rgb = CD'(12'hFFF);
      default: sprite_rgb = FG_RGB;
    endcase
  end

  // A corner hit flips both axes but advances the colour only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      color_idx <= '0;
    else if (tick && (nx.hit || ny.hit))
      color_idx <= color_idx + 2'd1;
  end
`else
  always_comb sprite_rgb = FG_RGB;
`endif

  // Pixel test uses the pre-update position, so the tick cycle still draws the old frame.
  always_comb begin
    in_active = ({1'b0, bus.x} < HA) && ({1'b0, bus.y} < VA);
    in_box    = ({1'b0, bus.x} >= {1'b0, box_x}) && ({1'b0, bus.x} < ({1'b0, box_x} + BOX)) &&
                ({1'b0, bus.y} >= {1'b0, box_y}) && ({1'b0, bus.y} < ({1'b0, box_y} + BOX));
    pix_rgb   = BG_RGB;
    if (!in_active)
      pix_rgb = '0;
    else if (in_box)
      pix_rgb = sprite_rgb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.box_rgb    <= '0;
      bus.frame_tick <= 1'b0;
      box_x          <= '0;
      box_y          <= '0;
      dir_x          <= 1'b1;
      dir_y          <= 1'b1;
    end else begin
      bus.box_rgb    <= pix_rgb;
      bus.frame_tick <= tick;
      if (tick) begin
        box_x <= nx.pos;
        dir_x <= nx.dir;
        box_y <= ny.pos;
        dir_y <= ny.dir;
      end
    end
  end

endmodule

// File: tb/tb_bounce_box_gen.sv
// Randomized self-checking bench for bounce_box_gen against a behavioural motion/pixel model.
`timescale 1ns/1ps
module tb_bounce_box_gen;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BS = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bounce_box_gen_if #(.CD(12)) bus ();

  bounce_box_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: sprite top-left corner, heading per axis, colour slot.
  int px, py, idx;
  bit mdx, mdy;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    px = 0; py = 0; mdx = 1'b1; mdy = 1'b1; idx = 0;
  endtask

  task automatic move(inout int p, inout bit d, input int s, input int far_wall, output bit hit);
    int np;
    hit = 1'b0;
    np  = d ? p + s : p - s;
    if (d && np >= far_wall) begin p = far_wall; d = 1'b0; hit = 1'b1; end
    else if (!d && np <= 0)  begin p = 0;        d = 1'b1; hit = 1'b1; end
    else p = np;
  endtask

  task automatic model_tick(input int s);
    bit hx, hy;
    if (s == 0) return;
    move(px, mdx, s, H - BS, hx);
    move(py, mdy, s, V - BS, hy);
`ifdef BOUNCE_BOX_COLOR_CYCLE_EN
    if (hx || hy) idx = (idx + 1) % 4;
`endif
  endtask

  function automatic int exp_pix(input int x, input int y);
    int pal [4];
    pal = '{32'hF00, 32'h0F0, 32'hFF0, 32'hFFF};
    if (x >= H || y >= V) return 0;
    if (x >= px && x < px + BS && y >= py && y < py + BS) return pal[idx];
    return 32'h00F;
  endfunction

  // Present one pixel, clock it, and compare the registered outputs one cycle later.
  task automatic drive(input int x, input int y, input int s);
    int  e;
    bit  tk;
    bus.x     = 11'(x);
    bus.y     = 11'(y);
    bus.speed = 2'(s);
    e  = exp_pix(x, y);
    tk = (x == 0 && y == V);
    @(posedge clk);
    #1;
    chk("box_rgb", int'(bus.box_rgb), e);
    chk("frame_tick", int'(bus.frame_tick), int'(tk));
    if (tk) begin
      model_tick(s);
      chk("box_x", int'(dut.box_x), px);
      chk("box_y", int'(dut.box_y), py);
      chk("dir_x", int'(dut.dir_x), int'(mdx));
      chk("dir_y", int'(dut.dir_y), int'(mdy));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_rgb", int'(bus.box_rgb), 0);
    chk("rst_tick", int'(bus.frame_tick), 0);
    chk("rst_box_x", int'(dut.box_x), 0);
    chk("rst_box_y", int'(dut.box_y), 0);
    chk("rst_dir_x", int'(dut.dir_x), 1);
    chk("rst_dir_y", int'(dut.dir_y), 1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int x, y, s;
    bus.x = '0; bus.y = '0; bus.speed = '0;
    reset = 1'b0;
    #2;
    do_reset();

    // Basic pixels and blanking.
    drive(0, 0, 0);
    chk("px_0_0", int'(bus.box_rgb), 32'hF00);
    drive(32, 0, 0);
    chk("px_32_0", int'(bus.box_rgb), 32'h00F);
    drive(640, 10, 0);
    drive(5, 480, 0);
    drive(31, 31, 0);
    drive(32, 31, 0);
    drive(639, 479, 0);

    // First tick at speed 3, then a frozen tick.
    drive(0, V, 3);
    chk("first_box_x", int'(dut.box_x), 3);
    chk("first_box_y", int'(dut.box_y), 3);
    drive(3, 3, 0);
    drive(2, 3, 0);
    drive(0, V, 0);
    chk("frozen_box_x", int'(dut.box_x), 3);

    // Walk the right wall: 606 -> clamp 608 -> 605.
    for (int k = 0; k < 201; k++) drive(0, V, 3);
    chk("walk_606", int'(dut.box_x), 606);
    drive(0, V, 3);
    chk("clamp_608", int'(dut.box_x), 608);
    chk("clamp_dir", int'(dut.dir_x), 0);
    drive(0, V, 3);
    chk("back_605", int'(dut.box_x), 605);
    drive(610, 460, 0);
    drive(604, 460, 0);

    // Randomized frames: mostly pixels near the sprite edges, periodic ticks.
    for (int n = 0; n < 6000; n++) begin
      s = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3);
      if ($urandom_range(0, 2) == 0) begin
        drive(0, V, s);
      end else if ($urandom_range(0, 1) == 0) begin
        x = px + $urandom_range(0, BS + 1) - 1;
        y = py + $urandom_range(0, BS + 1) - 1;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        drive(x, y, s);
      end else begin
        x = $urandom_range(0, 700);
        y = $urandom_range(0, 530);
        if (x == 0 && y == V) y = 0;
        drive(x, y, s);
      end
    end

    // Mid-line reset inside the sprite with a tick pending on the inputs.
    drive(px + 1, py + 1, 2);
    bus.x = '0; bus.y = 11'(V); bus.speed = 2'd2;
    #2;
    do_reset();
    for (int k = 0; k < 5; k++) drive(k + 1, 10, 2);
    drive(0, V - 1, 2);
    drive(0, V, 2);
    chk("post_rst_x", int'(dut.box_x), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bounce_box_gen.md
BOUNCE_BOX_GEN -- requirements
Module: bounce_box_gen

Interface
REQ-001: Parameter CD, default 12, gives the colour depth in bits of the pixel output.
REQ-002: Parameter H_ACTIVE, default 640, gives the visible pixels per line.
REQ-003: Parameter V_ACTIVE, default 480, gives the visible lines per frame.
REQ-004: Parameter BOX_SIZE, default 32, gives the square sprite edge in pixels.
REQ-005: Parameter FG_RGB, default 12'hF00, gives the sprite colour.
REQ-006: Parameter BG_RGB, default 12'h00F, gives the background colour.
REQ-007: clk  input  1  pixel clock; all state SHALL update on its rising edge.
REQ-008: reset  input  1  asynchronous, active-high reset.
REQ-009: x  input  11  current horizontal pixel count from the sync stage (hc).
REQ-010: y  input  11  current vertical line count from the sync stage (vc).
REQ-011: speed  input  2  per-frame step in pixels (0 freezes motion).
REQ-012: box_rgb  output  CD  registered pixel colour fed to the downstream colour/gray mux.
REQ-013: frame_tick  output  1  one-cycle registered pulse marking a position update.

Function
REQ-014: The tick condition SHALL be x==0 && y==V_ACTIVE; frame_tick SHALL be high exactly one cycle after that condition is true, i.e. once per frame.
REQ-015: Position registers box_x and box_y (11 bits each) and direction flags dir_x and dir_y (1 = increasing) SHALL update only on the tick condition.
REQ-016: speed SHALL be sampled on the tick condition; step = speed, zero-extended to 11 bits.
REQ-017: Moving right: if box_x+step >= H_ACTIVE-BOX_SIZE, then box_x <= H_ACTIVE-BOX_SIZE and dir_x <= 0; otherwise box_x <= box_x+step.
REQ-018: Moving left: if box_x <= step, then box_x <= 0 and dir_x <= 1; otherwise box_x <= box_x-step.
REQ-019: The Y axis SHALL follow the same rules as REQ-017 and REQ-018, using V_ACTIVE.
REQ-020: A corner hit SHALL flip both flags on the same tick, and that tick SHALL count as one bounce event.
REQ-021: With step=0, position and direction SHALL hold and no bounce event SHALL occur.
REQ-022: box_rgb SHALL be registered with 1-cycle latency from x/y.
REQ-023: When x >= H_ACTIVE or y >= V_ACTIVE, box_rgb SHALL be 0.
REQ-024: When box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE, box_rgb SHALL be the sprite colour.
REQ-025: For every other pixel, box_rgb SHALL be BG_RGB.
REQ-026: Pixel comparisons SHALL use the position values held before any same-cycle tick update.

Reset
REQ-027: On reset assertion, box_rgb, frame_tick, box_x and box_y SHALL immediately go to 0, with no clock required.
REQ-028: On reset assertion, dir_x and dir_y SHALL immediately go to 1, with no clock required.
REQ-029: On reset assertion, the colour index SHALL immediately go to 0, with no clock required.
REQ-030: A reset mid-frame SHALL discard any pending tick.
REQ-031: After reset deasserts, the first update SHALL occur at the next tick condition.

Configuration
REQ-032: Macro BOUNCE_BOX_COLOR_CYCLE_EN SHALL control sprite colour cycling.
REQ-033: When BOUNCE_BOX_COLOR_CYCLE_EN is defined, a 2-bit colour index SHALL increment by 1, wrapping 3 to 0, on each bounce event.
REQ-034: When BOUNCE_BOX_COLOR_CYCLE_EN is defined, the sprite colour SHALL be {FG_RGB, 12'h0F0, 12'hFF0, 12'hFFF}[index].
REQ-035: When BOUNCE_BOX_COLOR_CYCLE_EN is undefined, the index logic SHALL be absent and the sprite colour SHALL always be FG_RGB.

Verification
REQ-036: Reset then x=0,y=0 -> box_rgb=12'hF00 one cycle later; then x=32,y=0 -> box_rgb=12'h00F.
REQ-037: speed=3, one frame of x/y from reset -> frame_tick pulses once, box_x=3, box_y=3; speed=0 over the next frame -> position unchanged.
REQ-038: box_x=606, dir right, step 3 -> box_x=608, dir_x=0; next tick -> box_x=605.
REQ-039: Position (606,446), step 3, BOUNCE_BOX_COLOR_CYCLE_EN defined -> position (608,448), both flags 0, index goes 0->1 (once), then sprite colour 12'h0F0.
REQ-040: x=640,y=10 and x=5,y=480 -> box_rgb=0.
REQ-041: Reset asserted mid-line at box (100,50) -> box_rgb=0, box_x=0, box_y=0 without a clock edge; after release, no frame_tick until the next x=0,y=480.
